calc2_dut: RTL and testbench
============================

Name: calc2_dut

Overview:
- Four-port, tagged, multi-outstanding integer calculator: add, subtract, shift left, shift right.
- Each requester port sends a command, tag and two 32-bit operands, and receives a response, result and matching tag on its own output port.
- The block is the core of the calc2 verification environment and is wired to the calc2_bus interface (ports indexed 1..4).

Parameters:
- QUEUE_DEPTH, 4, command FIFO entries per port (one per tag value).
- PIPE_LAT, 3, execution pipeline stages from issue to response.

Ports:
- c_clk  input  1  functional clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- a_clk, b_clk  input  1 each  scan clocks; ignored.
- scan_in  input  1  ignored.
- scan_out  output  1  tied 0.
- req1..4_cmd_in  input  4 each  command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr; others invalid.
- req1..4_data_in  input  32 each  operand1 in command cycle, operand2 in next cycle.
- req1..4_tag_in  input  2 each  request tag, sampled in command cycle.
- out_data1..4  output  32 each  result.
- out_resp1..4  output  2 each  0 none, 1 success, 2 overflow/underflow/invalid, 3 reserved (never driven).
- out_tag1..4  output  2 each  tag of the responding request.

Behaviour:
- Reset: while reset=1 at a clock edge, clear all FIFOs, capture FSMs, pipeline valids and the arbiter pointer (pointer to port 1). All out_resp/out_data/out_tag = 0 from the first reset edge. One reset cycle suffices; reset mid-operation discards all in-flight work with no responses.
- Per-port capture FSM:
  - IDLE: cmd≠0 latches cmd, tag and data as op1, then goes to OP2.
  - OP2: latches data as op2, ignores cmd, pushes {cmd,tag,op1,op2} into the port FIFO, returns to IDLE.
  - A new command is accepted in the cycle directly after OP2.
- FIFO full: a push is dropped silently. This cannot occur when hosts keep at most 4 outstanding, uniquely tagged requests.
- Arbiter: one issue per cycle total, round-robin over non-empty FIFOs, starting after the last granted port. A push and a pop in the same cycle on one FIFO are both honoured.
- Pipeline: fixed PIPE_LAT stages carrying {port,tag,result,resp}. Results on a port come out in issue order; ports interleave arbitrarily.
- Latency: with an idle machine, the response is on the outputs exactly 4 cycles after the OP2 edge. That is 1 cycle enqueue/issue plus 3 stages; a command at cycle N gives a response at N+5.
- Response: out_resp/out_data/out_tag valid for exactly one cycle; otherwise all zero.
- Arithmetic (unsigned 32-bit):
  - add: 33-bit sum; carry → resp 2, data 0; else resp 1, data = sum.
  - sub: op2>op1 → resp 2, data 0; else resp 1, data = op1−op2 (equal operands give 0, resp 1).
  - shl/shr: logical shift of op1 by op2[4:0], zero fill; op2[31:5] ignored; always resp 1.
  - invalid cmd (3,4,7..15): resp 2, data 0, tag echoed.
- Reused tags: each request gets its own response; uniqueness is not checked.

Test Plan:
- Reset 1 cycle, then port1 add 0x0000_0005 + 0x0000_0003, tag 2 → out_resp1=1, out_data1=0x8, out_tag1=2, exactly 4 cycles after the op2 cycle; other ports stay 0.
- Port2 add 0xFFFF_FFFF + 0x1 → resp 2, data 0; port2 sub 3−5 → resp 2; sub 5−5 → resp 1, data 0.
- Port3 shl 0x1 by 31 → 0x8000_0000. Shr 0x8000_0000 by 0x21 (uses low 5 bits = 1) → 0x4000_0000. Both resp 1.
- Port4 cmd 4 → resp 2, data 0, correct tag.
- All 4 ports issue in the same cycle, each 4 back-to-back commands with tags 0..3:
  - All 16 responses arrive on the correct ports with correct tags.
  - Per-port order is preserved.
  - Round-robin order is port1, 2, 3, 4 for the first issue round.
- Assert reset while 8 commands are in flight → no responses afterwards; a fresh add completes normally.

Source files
------------

// File: rtl/calc2_dut.sv
// ---------------------------------------------------------------------------
// calc2_dut : four-port tagged integer calculator (add, sub, shl, shr)
//
// Each requester port presents a command with operand1 and a tag in one
// cycle, then operand2 in the next cycle. The request is queued per port,
// a round-robin arbiter issues one request per cycle into a fixed-latency
// execution pipeline, and the result comes back on the same port's
// outputs together with the request tag.
//
// Ports
//   c_clk            functional clock, rising edge
//   reset            synchronous, active-high
//   a_clk, b_clk     scan clocks (unused)
//   scan_in          scan input (unused)
//   scan_out         scan output, tied low
//   reqN_cmd_in[3:0] command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//   reqN_data_in     operand1 in command cycle, operand2 in the next cycle
//   reqN_tag_in      request tag, sampled in the command cycle
//   out_dataN        result (zero when no response)
//   out_respN        0 none, 1 success, 2 overflow/underflow/invalid
//   out_tagN         tag of the responding request (zero when no response)
// ---------------------------------------------------------------------------
module calc2_dut #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PIPE_LAT    = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        a_clk,
    input  logic        b_clk,
    input  logic        scan_in,
    output logic        scan_out,
    input  logic [3:0]  req1_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [1:0]  req1_tag_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [31:0] req2_data_in,
    input  logic [1:0]  req2_tag_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [31:0] req3_data_in,
    input  logic [1:0]  req3_tag_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req4_data_in,
    input  logic [1:0]  req4_tag_in,
    output logic [31:0] out_data1,
    output logic [1:0]  out_resp1,
    output logic [1:0]  out_tag1,
    output logic [31:0] out_data2,
    output logic [1:0]  out_resp2,
    output logic [1:0]  out_tag2,
    output logic [31:0] out_data3,
    output logic [1:0]  out_resp3,
    output logic [1:0]  out_tag3,
    output logic [31:0] out_data4,
    output logic [1:0]  out_resp4,
    output logic [1:0]  out_tag4
);

    localparam int NPORT  = 4;
    localparam int DATA_W = 32;
    localparam int PW     = $clog2(QUEUE_DEPTH);
    localparam int CW     = $clog2(QUEUE_DEPTH + 1);
    localparam int ENT_W  = 4 + 2 + DATA_W + DATA_W;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic {ST_IDLE, ST_OP2} state_t;

    // Scan pins are present only for the test environment.
    logic w_unused_scan;
    assign w_unused_scan = a_clk ^ b_clk ^ scan_in;
    assign scan_out      = 1'b0;

    // Result word is {resp[1:0], data[31:0]}.
    function automatic logic [DATA_W+1:0] f_calc(input logic [3:0]        cmd,
                                                 input logic [DATA_W-1:0] op1,
                                                 input logic [DATA_W-1:0] op2);
        logic [DATA_W:0]   sum;
        logic [DATA_W+1:0] res;
        sum = {1'b0, op1} + {1'b0, op2};
        case (cmd)
            4'd1:    res = sum[DATA_W] ? {RESP_ERR, {DATA_W{1'b0}}} : {RESP_OK, sum[DATA_W-1:0]};
            4'd2:    res = (op2 > op1) ? {RESP_ERR, {DATA_W{1'b0}}} : {RESP_OK, op1 - op2};
            4'd5:    res = {RESP_OK, op1 << op2[4:0]};
            4'd6:    res = {RESP_OK, op1 >> op2[4:0]};
            default: res = {RESP_ERR, {DATA_W{1'b0}}};
        endcase
        return res;
    endfunction

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] v);
        return (v == PW'(QUEUE_DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    // Gather the per-port input pins into arrays.
    logic [3:0]        w_cmd_in  [NPORT];
    logic [DATA_W-1:0] w_data_in [NPORT];
    logic [1:0]        w_tag_in  [NPORT];

    assign w_cmd_in[0]  = req1_cmd_in;
    assign w_cmd_in[1]  = req2_cmd_in;
    assign w_cmd_in[2]  = req3_cmd_in;
    assign w_cmd_in[3]  = req4_cmd_in;
    assign w_data_in[0] = req1_data_in;
    assign w_data_in[1] = req2_data_in;
    assign w_data_in[2] = req3_data_in;
    assign w_data_in[3] = req4_data_in;
    assign w_tag_in[0]  = req1_tag_in;
    assign w_tag_in[1]  = req2_tag_in;
    assign w_tag_in[2]  = req3_tag_in;
    assign w_tag_in[3]  = req4_tag_in;

    // ---- capture: command/op1 cycle, then op2 cycle ----
    state_t            r_state [NPORT];
    logic [3:0]        r_cmd   [NPORT];
    logic [1:0]        r_tag   [NPORT];
    logic [DATA_W-1:0] r_op1   [NPORT];

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (reset) begin
                r_state[p] <= ST_IDLE;
            end else begin
                case (r_state[p])
                    ST_IDLE: if (w_cmd_in[p] != 4'd0) r_state[p] <= ST_OP2;
                    ST_OP2:  r_state[p] <= ST_IDLE;
                    default: r_state[p] <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (r_state[p] == ST_IDLE && w_cmd_in[p] != 4'd0) begin
                r_cmd[p] <= w_cmd_in[p];
                r_tag[p] <= w_tag_in[p];
                r_op1[p] <= w_data_in[p];
            end
        end
    end

    // ---- per-port command FIFOs ----
    logic [ENT_W-1:0] r_mem  [NPORT][QUEUE_DEPTH];
    logic [PW-1:0]    r_wptr [NPORT];
    logic [PW-1:0]    r_rptr [NPORT];
    logic [CW-1:0]    r_cnt  [NPORT];
    logic [ENT_W-1:0] w_entry [NPORT];
    logic [NPORT-1:0] w_push;
    logic [NPORT-1:0] w_wr;
    logic [NPORT-1:0] w_pop;
    logic [NPORT-1:0] w_empty;

    always_comb begin
        w_push  = '0;
        w_wr    = '0;
        w_empty = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_entry[p] = {r_cmd[p], r_tag[p], r_op1[p], w_data_in[p]};
            w_push[p]  = (r_state[p] == ST_OP2);
            w_empty[p] = (r_cnt[p] == '0);
            // A full FIFO still accepts a push when the head leaves this cycle.
            w_wr[p]    = w_push[p] && ((r_cnt[p] != CW'(QUEUE_DEPTH)) || w_pop[p]);
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (w_wr[p]) r_mem[p][r_wptr[p]] <= w_entry[p];
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (reset) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end else begin
                if (w_wr[p])  r_wptr[p] <= f_inc(r_wptr[p]);
                if (w_pop[p]) r_rptr[p] <= f_inc(r_rptr[p]);
                case ({w_wr[p], w_pop[p]})
                    2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
                    2'b01:   r_cnt[p] <= r_cnt[p] - 1'b1;
                    default: r_cnt[p] <= r_cnt[p];
                endcase
            end
        end
    end

    // ---- round-robin arbiter: search starts one past the last grant ----
    logic [1:0]       r_last;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt_port;
    logic [ENT_W-1:0] w_head;

    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_port = '0;
        w_pop      = '0;
        for (int k = 1; k <= NPORT; k++) begin
            if (!w_gnt_vld && !w_empty[r_last + 2'(k)]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_port = r_last + 2'(k);
            end
        end
        w_pop[w_gnt_port] = w_gnt_vld;
    end

    assign w_head = r_mem[w_gnt_port][r_rptr[w_gnt_port]];

    // ---- issue register ----
    logic              r_vld_p0;
    logic [1:0]        r_port_p0;
    logic [3:0]        r_cmd_p0;
    logic [1:0]        r_tag_p0;
    logic [DATA_W-1:0] r_op1_p0;
    logic [DATA_W-1:0] r_op2_p0;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_vld_p0 <= 1'b0;
            r_last   <= 2'd3;   // so the first search begins at port 1
        end else begin
            r_vld_p0 <= w_gnt_vld;
            if (w_gnt_vld) r_last <= w_gnt_port;
        end
    end

    always_ff @(posedge c_clk) begin
        r_port_p0 <= w_gnt_port;
        {r_cmd_p0, r_tag_p0, r_op1_p0, r_op2_p0} <= w_head;
    end

    // ---- execution pipeline, PIPE_LAT stages; last stage drives outputs ----
    logic              r_vld_px  [PIPE_LAT];
    logic [1:0]        r_port_px [PIPE_LAT];
    logic [1:0]        r_tag_px  [PIPE_LAT];
    logic [DATA_W+1:0] r_res_px  [PIPE_LAT];

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) r_vld_px[i] <= 1'b0;
        end else begin
            r_vld_px[0] <= r_vld_p0;
            for (int i = 1; i < PIPE_LAT; i++) r_vld_px[i] <= r_vld_px[i-1];
        end
    end

    always_ff @(posedge c_clk) begin
        r_port_px[0] <= r_port_p0;
        r_tag_px[0]  <= r_tag_p0;
        r_res_px[0]  <= f_calc(r_cmd_p0, r_op1_p0, r_op2_p0);
        for (int i = 1; i < PIPE_LAT; i++) begin
            r_port_px[i] <= r_port_px[i-1];
            r_tag_px[i]  <= r_tag_px[i-1];
            r_res_px[i]  <= r_res_px[i-1];
        end
    end

    // ---- output steering: only the addressed port sees a nonzero word ----
    logic [NPORT-1:0]  w_sel;
    logic [DATA_W-1:0] w_odata;
    logic [1:0]        w_oresp;
    logic [1:0]        w_otag;

    assign w_odata = r_res_px[PIPE_LAT-1][DATA_W-1:0];
    assign w_oresp = r_res_px[PIPE_LAT-1][DATA_W+1:DATA_W];
    assign w_otag  = r_tag_px[PIPE_LAT-1];

    always_comb begin
        w_sel = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_sel[p] = r_vld_px[PIPE_LAT-1] && (r_port_px[PIPE_LAT-1] == 2'(p));
        end
    end

    assign out_data1 = w_sel[0] ? w_odata : '0;
    assign out_resp1 = w_sel[0] ? w_oresp : '0;
    assign out_tag1  = w_sel[0] ? w_otag  : '0;
    assign out_data2 = w_sel[1] ? w_odata : '0;
    assign out_resp2 = w_sel[1] ? w_oresp : '0;
    assign out_tag2  = w_sel[1] ? w_otag  : '0;
    assign out_data3 = w_sel[2] ? w_odata : '0;
    assign out_resp3 = w_sel[2] ? w_oresp : '0;
    assign out_tag3  = w_sel[2] ? w_otag  : '0;
    assign out_data4 = w_sel[3] ? w_odata : '0;
    assign out_resp4 = w_sel[3] ? w_oresp : '0;
    assign out_tag4  = w_sel[3] ? w_otag  : '0;

endmodule

// File: tb/tb_calc2_dut.sv
// ---------------------------------------------------------------------------
// tb_calc2_dut : scoreboard bench for calc2_dut. Drivers push the expected
// response of each request into a queue; a monitor on the falling edge pops
// the oldest entry for a port whenever that port shows a response.
// ---------------------------------------------------------------------------
module tb_calc2_dut;

    logic        clk;
    logic        reset;
    logic        scan_out;
    logic [3:0]  cmd_i  [4];
    logic [31:0] data_i [4];
    logic [1:0]  tag_i  [4];
    logic [31:0] o_data [4];
    logic [1:0]  o_resp [4];
    logic [1:0]  o_tag  [4];

    calc2_dut #(.QUEUE_DEPTH(4), .PIPE_LAT(3)) dut (
        .c_clk(clk), .reset(reset), .a_clk(1'b0), .b_clk(1'b0),
        .scan_in(1'b0), .scan_out(scan_out),
        .req1_cmd_in(cmd_i[0]), .req1_data_in(data_i[0]), .req1_tag_in(tag_i[0]),
        .req2_cmd_in(cmd_i[1]), .req2_data_in(data_i[1]), .req2_tag_in(tag_i[1]),
        .req3_cmd_in(cmd_i[2]), .req3_data_in(data_i[2]), .req3_tag_in(tag_i[2]),
        .req4_cmd_in(cmd_i[3]), .req4_data_in(data_i[3]), .req4_tag_in(tag_i[3]),
        .out_data1(o_data[0]), .out_resp1(o_resp[0]), .out_tag1(o_tag[0]),
        .out_data2(o_data[1]), .out_resp2(o_resp[1]), .out_tag2(o_tag[1]),
        .out_data3(o_data[2]), .out_resp3(o_resp[2]), .out_tag3(o_tag[2]),
        .out_data4(o_data[3]), .out_resp4(o_resp[3]), .out_tag4(o_tag[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          due;     // -1: arrival cycle not checked
    } exp_t;

    exp_t sbq[$];
    int   ord[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int p, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s port%0d actual=%0h required=%0h (cycle %0d)", nm, p + 1, act, exp, cyc);
        end
    endtask

    // Monitor: compare every port on every falling edge.
    always @(negedge clk) begin
        int idx;
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            if (o_resp[p] != 2'd0) begin
                ord.push_back(p);
                idx = -1;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].port == p) begin
                        idx = i;
                        break;
                    end
                end
                if (idx < 0) begin
                    chk("unexpected_resp", p, 64'(o_resp[p]), 64'd0);
                end else begin
                    e = sbq[idx];
                    sbq.delete(idx);
                    chk("resp", p, 64'(o_resp[p]), 64'(e.resp));
                    chk("data", p, 64'(o_data[p]), 64'(e.data));
                    chk("tag",  p, 64'(o_tag[p]),  64'(e.tag));
                    if (e.due >= 0) chk("latency_cycle", p, 64'(cyc), 64'(e.due));
                end
            end else begin
                chk("idle_data", p, 64'(o_data[p]), 64'd0);
                chk("idle_tag",  p, 64'(o_tag[p]),  64'd0);
            end
        end
    end

    // Drive one request: command/op1 cycle then op2 cycle.
    task automatic send(input int p, input logic [3:0] c, input logic [1:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed,
                        input bit want, input bit chk_lat);
        exp_t e;
        @(negedge clk);
        cmd_i[p]  = c;
        tag_i[p]  = t;
        data_i[p] = a;
        if (want) begin
            e.port = p; e.resp = er; e.data = ed; e.tag = t;
            // command sampled at edge cyc+1, response visible after edge cyc+6
            e.due  = chk_lat ? cyc + 6 : -1;
            sbq.push_back(e);
        end
        @(negedge clk);
        cmd_i[p]  = 4'd0;
        tag_i[p]  = 2'd0;
        data_i[p] = b;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sbq.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        if (sbq.size() != 0) chk("drain_timeout", 0, 64'(sbq.size()), 64'd0);
    endtask

    // Four back-to-back requests per port, tags 0..3, a different op per port.
    task automatic burst(input int p);
        logic [31:0] a;
        for (int t = 0; t < 4; t++) begin
            a = 32'h100 * (p + 1) + 32'(t);
            case (p)
                0: send(p, 4'd1, 2'(t), a, 32'(t), 2'd1, a + 32'(t), 1'b1, 1'b0);
                1: send(p, 4'd2, 2'(t), a, 32'(t), 2'd1, a - 32'(t), 1'b1, 1'b0);
                2: send(p, 4'd5, 2'(t), a, 32'(t), 2'd1, a << t,     1'b1, 1'b0);
                default: send(p, 4'd6, 2'(t), a, 32'(t), 2'd1, a >> t, 1'b1, 1'b0);
            endcase
        end
    endtask

    task automatic flight(input int p);
        send(p, 4'd1, 2'd0, 32'd1, 32'd2, 2'd1, 32'd3, 1'b0, 1'b0);
        send(p, 4'd2, 2'd1, 32'd9, 32'd2, 2'd1, 32'd7, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout port0 actual=%0d required=0", sbq.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            cmd_i[p] = 4'd0; data_i[p] = 32'd0; tag_i[p] = 2'd0;
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) chk("reset_resp", p, 64'(o_resp[p]), 64'd0);
        chk("scan_out", 0, 64'(scan_out), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic add with exact latency.
        send(0, 4'd1, 2'd2, 32'h5, 32'h3, 2'd1, 32'h8, 1'b1, 1'b1);
        drain(40);

        // Port 2: carry, underflow, equal operands.
        send(1, 4'd1, 2'd0, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, 1'b1, 1'b1);
        send(1, 4'd2, 2'd1, 32'h3, 32'h5, 2'd2, 32'h0, 1'b1, 1'b1);
        send(1, 4'd2, 2'd3, 32'h5, 32'h5, 2'd1, 32'h0, 1'b1, 1'b1);
        send(1, 4'd1, 2'd2, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        drain(40);

        // Port 3: shifts, including an amount above 31.
        send(2, 4'd5, 2'd1, 32'h1, 32'd31, 2'd1, 32'h8000_0000, 1'b1, 1'b1);
        send(2, 4'd6, 2'd2, 32'h8000_0000, 32'h21, 2'd1, 32'h4000_0000, 1'b1, 1'b1);
        send(2, 4'd5, 2'd3, 32'h1234_5678, 32'h24, 2'd1, 32'h2345_6780, 1'b1, 1'b1);
        drain(40);

        // Port 4: invalid commands echo the tag.
        send(3, 4'd4,  2'd1, 32'h11, 32'h22, 2'd2, 32'h0, 1'b1, 1'b1);
        send(3, 4'd15, 2'd3, 32'h11, 32'h22, 2'd2, 32'h0, 1'b1, 1'b1);
        drain(40);

        // All ports at once, four deep.
        ord.delete();
        fork
            burst(0);
            burst(1);
            burst(2);
            burst(3);
        join
        drain(100);
        chk("burst_count", 0, 64'(ord.size()), 64'd16);
        for (int i = 0; i < 4; i++) chk("rr_order", i, 64'(ord.size() > i ? ord[i] : 99), 64'(i));

        // Reset with eight requests in flight: nothing may come out.
        fork
            flight(0);
            flight(1);
            flight(2);
            flight(3);
        join
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Fresh request after the flush.
        send(3, 4'd1, 2'd1, 32'h1234, 32'h1, 2'd1, 32'h1235, 1'b1, 1'b1);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
